dro_bank: RTL and testbench

DRO_BANK -- requirements
Module: dro_bank

---
 rtl/dro_bank.sv | 67 ++++++
 tb/tb_dro_bank.sv | 121 ++++++++++++
 2 files changed

// File: rtl/dro_bank.sv
// dro_bank: bank of destructive-readout cells with set-to-read separation checking; DRO_BANK_VIOL_CNT_EN enables the violation counter
module dro_bank #(
  parameter int CHANNELS = 4,
  parameter int MIN_SEP  = 3,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] set,
  input  logic [CHANNELS-1:0] reset,
  input  logic                clr_viol,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] full,
  output logic [CHANNELS-1:0] viol,
  output logic [CNT_W-1:0]    viol_cnt
);
  localparam int SW = $clog2(MIN_SEP + 1);
  localparam logic [SW-1:0] SEP_MAX = SW'(MIN_SEP);
  typedef enum logic {EMPTY, FULL} st_t;
  st_t st [CHANNELS];
  st_t st_nx [CHANNELS];
  logic [SW-1:0] sep [CHANNELS];
  logic [SW-1:0] sep_nx [CHANNELS];
  logic [CHANNELS-1:0] rd_ok, v;
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      full[i]   = st[i] == FULL;
      rd_ok[i]  = reset[i] & ~set[i] & full[i] & (sep[i] >= SEP_MAX);
      v[i]      = reset[i] & (set[i] | (full[i] & (sep[i] < SEP_MAX)));
      st_nx[i]  = reset[i] ? EMPTY : (set[i] ? FULL : st[i]);
      sep_nx[i] = (set[i] & ~reset[i] & ~full[i]) ? '0 : (sep[i] >= SEP_MAX ? SEP_MAX : sep[i] + 1'b1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        st[i]  <= EMPTY;
        sep[i] <= SEP_MAX;
      end
      out  <= '0;
      viol <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        st[i]  <= st_nx[i];
        sep[i] <= sep_nx[i];
      end
      out  <= rd_ok;
      viol <= clr_viol ? v : (viol | v);
    end
  end
`ifdef DRO_BANK_VIOL_CNT_EN
  localparam int AW = CNT_W + 7;
  localparam logic [AW-1:0] CMAX = {7'b0, {CNT_W{1'b1}}};
  logic [AW-1:0] nv, acc;
  always_comb begin
    nv = '0;
    for (int i = 0; i < CHANNELS; i++) nv = nv + AW'(v[i]);
    acc = (clr_viol ? '0 : {7'b0, viol_cnt}) + nv;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) viol_cnt <= '0;
    else viol_cnt <= acc > CMAX ? '1 : acc[CNT_W-1:0];
  end
`else
  assign viol_cnt = '0;
`endif
endmodule

// File: tb/tb_dro_bank.sv
// tb_dro_bank: directed and random checks of dro_bank against a cycle-number based reference model
module tb_dro_bank;
  localparam int CH = 4, MS = 3, CW = 4;
  logic clk = 0, rst_n = 0, clr_viol = 0;
  logic [CH-1:0] set = '0, reset = '0, out, full, viol;
  logic [CW-1:0] viol_cnt;
  int tests = 0, fails = 0;
  int n = 0;
  bit fm [CH];
  int sc [CH];
  logic [CH-1:0] vm = '0, eo = '0;
  int cm = 0;

  dro_bank #(.CHANNELS(CH), .MIN_SEP(MS), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .set(set), .reset(reset), .clr_viol(clr_viol),
    .out(out), .full(full), .viol(viol), .viol_cnt(viol_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] cnt_exp();
`ifdef DRO_BANK_VIOL_CNT_EN
    return CW'(cm);
`else
    return '0;
`endif
  endfunction

  function automatic logic [CH-1:0] full_exp();
    logic [CH-1:0] f;
    for (int i = 0; i < CH; i++) f[i] = fm[i];
    return f;
  endfunction

  task automatic check_all(input string tag);
    tests++;
    assert (out === eo) else begin fails++; $error("FAIL %s out obs=%b exp=%b", tag, out, eo); end
    tests++;
    assert (full === full_exp()) else begin fails++; $error("FAIL %s full obs=%b exp=%b", tag, full, full_exp()); end
    tests++;
    assert (viol === vm) else begin fails++; $error("FAIL %s viol obs=%b exp=%b", tag, viol, vm); end
    tests++;
    assert (viol_cnt === cnt_exp()) else begin fails++; $error("FAIL %s viol_cnt obs=%0d exp=%0d", tag, viol_cnt, cnt_exp()); end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) fm[i] = 0;
    vm = '0; cm = 0; eo = '0;
  endtask

  // A read is legal when at least MS full cycles separate the set cycle from the read cycle.
  task automatic step(input logic [CH-1:0] s, input logic [CH-1:0] r, input logic c, input string tag);
    logic [CH-1:0] vb;
    set = s; reset = r; clr_viol = c;
    vb = '0; eo = '0;
    for (int i = 0; i < CH; i++) begin
      if (r[i] && s[i]) begin vb[i] = 1; fm[i] = 0; end
      else if (r[i]) begin
        if (fm[i]) begin
          if (n - sc[i] - 1 >= MS) eo[i] = 1; else vb[i] = 1;
        end
        fm[i] = 0;
      end else if (s[i] && !fm[i]) begin fm[i] = 1; sc[i] = n; end
    end
    vm = c ? vb : (vm | vb);
    cm = (c ? 0 : cm) + $countones(vb);
    if (cm > 15) cm = 15;
    n++;
    @(posedge clk); #1;
    set = '0; reset = '0; clr_viol = 0;
    check_all(tag);
  endtask

  task automatic idle(input int k, input string tag);
    for (int j = 0; j < k; j++) step('0, '0, 0, tag);
  endtask

  initial begin
    model_reset();
    #2 check_all("rst");
    #10 rst_n = 1;
    step(4'b0001, '0, 0, "r30_set");
    idle(4, "r30_hold");
    step('0, 4'b0001, 0, "r30_rd");
    idle(1, "r30_after");
    idle(3, "gap");
    step(4'b0010, '0, 0, "r31_set");
    idle(1, "r31_wait");
    step('0, 4'b0010, 0, "r31_rd");
    idle(1, "r31_after");
    step('0, '0, 1, "clr");
    step(4'b0011, 4'b0011, 0, "r32_both");
    step('0, 4'b0100, 0, "r32_empty_rd");
    step(4'b0001, '0, 0, "edge_set");
    idle(2, "edge_wait");
    step('0, 4'b0001, 0, "edge_rd_early");
    step(4'b0001, '0, 0, "edge_set2");
    idle(3, "edge_wait2");
    step('0, 4'b0001, 0, "edge_rd_min");
    step(4'b0100, '0, 0, "ign_set1");
    step(4'b0100, '0, 0, "ign_set2");
    idle(2, "ign_wait");
    step('0, 4'b0100, 0, "ign_rd");
    for (int j = 0; j < 20; j++) step(4'b1000, 4'b1000, 0, "r33_sat");
    step(4'b0001, 4'b0001, 1, "r33_clr");
    step(4'b0100, '0, 0, "r34_set");
    idle(3, "r34_wait");
    #3 rst_n = 0;
    #1 model_reset();
    check_all("r34_async");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    step('0, 4'b0100, 0, "r34_rd");
    idle(2, "r34_after");
    for (int j = 0; j < 400; j++)
      step(CH'($urandom) & CH'($urandom), CH'($urandom) & CH'($urandom) & CH'($urandom),
           ($urandom_range(15) == 0), "rand");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
